// File: rtl/dft_arb_pkg.sv
// Shared definitions for the DFT scan-chain readout arbiter: session state
// encoding and the idle-watchdog limit.
package dft_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WD_LIMIT = 1024;

endpackage

// File: rtl/dft_scan_arb_rr_arbiter.sv
// Combinational round-robin picker: first requesting, unmasked line at or
// after ptr wins; grant is one-hot, valid flags that anything won.
module rr_arbiter #(
  parameter int width = 16
) (
  input  logic [width-1:0]         req,
  input  logic [width-1:0]         mask,
  input  logic [$clog2(width)-1:0] ptr,
  output logic [width-1:0]         grant,
  output logic                     valid
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < width; i++) begin
      idx = int'(ptr) + i;
      if (idx >= width) idx = idx - width;
      if (!valid && req[idx] && mask[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dft_scan_arb.sv
// Scan-chain readout arbiter: round-robin grants chain words into a shared
// buffer write port. Optional idle watchdog built when DFT_SCAN_ARB_WATCHDOG_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; no grants
// ST_RUN  | arbitrating chain requests, one registered grant per cycle
// ST_DONE | one-cycle session-end pulse, then back to ST_IDLE
module dft_scan_arb
  import dft_arb_pkg::*;
#(
  parameter int p_sc_nbr   = 16,
  parameter int depth_log2 = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [p_sc_nbr-1:0]    sc_req,
  input  logic [32*p_sc_nbr-1:0] sc_data,
  input  logic [p_sc_nbr-1:0]    sc_last,
  output logic [p_sc_nbr-1:0]    sc_ack,
  output logic                   wr_en,
  output logic [31:0]            wr_addr,
  output logic [31:0]            wr_data,
  output logic                   busy,
  output logic                   done,
  output logic [p_sc_nbr-1:0]    fin_mask,
  output logic [p_sc_nbr-1:0]    ovf_mask,
  output logic                   timeout
);

  localparam int IW = $clog2(p_sc_nbr);
  localparam int CW = depth_log2 + 1;
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {depth_log2{1'b0}}};

  state_t              state, state_nxt;
  logic [p_sc_nbr-1:0] grant;
  logic                grant_vld;
  logic                grant_en;
  logic                wd_expire;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       gidx;
  logic [CW-1:0]       gcnt;
  logic [CW-1:0]       cnt [p_sc_nbr];

  // A chain acked this cycle still shows its old request, so it sits out.
  rr_arbiter #(.width(p_sc_nbr)) u_rr_arbiter (
    .req   (sc_req),
    .mask  (~sc_ack & ~fin_mask),
    .ptr   (ptr),
    .grant (grant),
    .valid (grant_vld)
  );

  assign grant_en = (state == ST_RUN) && !abort && grant_vld;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < p_sc_nbr; i++) begin
      if (grant[i]) gidx = IW'(i);
    end
    gcnt = cnt[gidx];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (abort || (&fin_mask) || wd_expire) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sc_ack   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      fin_mask <= '0;
      ovf_mask <= '0;
      ptr      <= '0;
      for (int i = 0; i < p_sc_nbr; i++) cnt[i] <= '0;
    end else begin
      sc_ack  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      if (state == ST_IDLE && start) begin
        fin_mask <= '0;
        ovf_mask <= '0;
        for (int i = 0; i < p_sc_nbr; i++) cnt[i] <= '0;
      end else if (grant_en) begin
        sc_ack         <= grant;
        ptr            <= (gidx == IW'(p_sc_nbr - 1)) ? '0 : gidx + IW'(1);
        fin_mask[gidx] <= fin_mask[gidx] | sc_last[gidx];
        // A full chain still gets its word acked so it can drain, but nothing is written.
        if (gcnt == CNT_FULL) begin
          ovf_mask[gidx] <= 1'b1;
        end else begin
          wr_en     <= 1'b1;
          wr_addr   <= 32'({gidx, gcnt[depth_log2-1:0]});
          wr_data   <= sc_data[32*int'(gidx) +: 32];
          cnt[gidx] <= gcnt + CW'(1);
        end
      end
    end
  end

`ifdef DFT_SCAN_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WD_LIMIT);

  logic [WDW-1:0] wd_cnt;
  logic           timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      wd_cnt    <= WDW'(WD_LIMIT - 1);
      timeout_q <= 1'b0;
    end else if (state == ST_RUN) begin
      if (grant_vld)          wd_cnt <= WDW'(WD_LIMIT - 1);
      else if (wd_cnt != '0)  wd_cnt <= wd_cnt - WDW'(1);
      if (wd_expire) timeout_q <= 1'b1;
    end
  end

  assign wd_expire = (state == ST_RUN) && !abort && !grant_vld && (wd_cnt == '0);
  assign timeout   = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
